// File: rtl/i2s_tdm_source.sv
// I2S / left-justified / TDM serial source: parallel multichannel frames in through
// valid/ready, BCK, LRCK and serial data out, with underrun flagging and counting.
module i2s_tdm_source #(
  parameter int WIDTH     = 24,
  parameter int SLOT_BITS = 32,
  parameter int CHANNELS  = 2,
  parameter int CLK_DIV   = 2,
  parameter int MODE      = 0
) (
  input  logic                        clk,
  input  logic                        I2S_RST,
  input  logic                        enable,
  input  logic [CHANNELS*WIDTH-1:0]   s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic                        bck,
  output logic                        lrck,
  output logic                        sdata,
  output logic                        underrun,
  output logic [7:0]                  underrun_cnt
);

  // Handshake: s_ready is a decode of registered state (plus enable) and never looks
  // at s_valid; a frame is taken on the rising clk edge that ends a cycle with
  // s_ready && s_valid. s_ready with s_valid low is an underrun.

  localparam int FRAME = CHANNELS * SLOT_BITS;
  localparam int BCW   = $clog2(FRAME);
  localparam int DCW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DCW-1:0] DC_LAST = DCW'(CLK_DIV - 1);
  localparam logic [BCW-1:0] BC_LAST = BCW'(FRAME - 1);
  localparam logic [BCW-1:0] BC_HALF = BCW'(FRAME / 2);

  logic [DCW-1:0]   dc;
  logic [BCW-1:0]   bc;
  logic [BCW-1:0]   bc_next;
  logic [FRAME-1:0] shreg;
  logic [FRAME-1:0] frame_word;
  logic             bck_q;
  logic             lrck_q;
  logic             dly;
  logic             running;
  logic             underrun_q;
  logic [7:0]       cnt;
  logic             active;
  logic             tick;
  logic             fall;
  logic             boundary;
  logic             load;
  logic             stop;

  // The divider keeps running while a frame is in flight even if enable has dropped.
  assign active   = running | enable;
  assign tick     = active && (dc == DC_LAST);
  assign fall     = tick && bck_q;
  assign boundary = fall && (bc == BC_LAST);
  assign load     = boundary && enable;
  assign stop     = boundary && !enable;
  assign bc_next  = (bc == BC_LAST) ? '0 : bc + 1'b1;

  always_comb begin
    frame_word = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      frame_word[FRAME-1-c*SLOT_BITS -: WIDTH] = s_data[c*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge I2S_RST) begin
    if (!I2S_RST) begin
      dc         <= '0;
      bc         <= BC_LAST;
      bck_q      <= 1'b0;
      lrck_q     <= 1'b0;
      shreg      <= '0;
      dly        <= 1'b0;
      running    <= 1'b0;
      underrun_q <= 1'b0;
      cnt        <= 8'd0;
    end else begin
      underrun_q <= load && !s_valid;
      if (load && !s_valid && (cnt != 8'hFF)) cnt <= cnt + 8'd1;
      if (active) begin
        running <= !stop;
        dc      <= tick ? '0 : dc + 1'b1;
      end
      if (tick) bck_q <= ~bck_q;
      if (fall) begin
        if (stop) begin
          // Park at the frame end with quiet outputs; bc stays at FRAME-1.
          lrck_q <= 1'b0;
          shreg  <= '0;
          dly    <= 1'b0;
        end else begin
          bc     <= bc_next;
          lrck_q <= (bc_next >= BC_HALF);
          dly    <= shreg[FRAME-1];
          if (load) shreg <= s_valid ? frame_word : '0;
          else      shreg <= shreg << 1;
        end
      end
    end
  end

  assign s_ready      = load;
  assign bck          = bck_q;
  assign lrck         = lrck_q;
  assign sdata        = (MODE == 1) ? shreg[FRAME-1] : dly;
  assign underrun     = underrun_q;
  assign underrun_cnt = cnt;

endmodule
